// File: rtl/conv_viterbi_dec_if.sv
// rtl/conv_viterbi_dec_if.sv - symbol input and decoded-bit output bundle for conv_viterbi_dec
interface conv_viterbi_dec_if #(
   parameter int PM_W = 8
);
   logic            load;
   logic [1:0]      seed;
   logic            valid_in;
   logic            r1;
   logic            r2;
   logic            ready;
   logic            data_out;
   logic            valid_out;
   logic [PM_W-1:0] metric_out;

   modport master (
      output load, seed, valid_in, r1, r2,
      input  ready, data_out, valid_out, metric_out
   );

   modport slave (
      input  load, seed, valid_in, r1, r2,
      output ready, data_out, valid_out, metric_out
   );
endinterface

// File: rtl/conv_viterbi_dec.sv
// rtl/conv_viterbi_dec.sv - hard-decision K=3 (7,5) Viterbi decoder, full-frame traceback
// Optional build macro: VITDEC_ZERO_TERM_EN forces traceback from state 0.
module conv_viterbi_dec #(
   parameter int FRAME_LEN = 40,
   parameter int PM_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   conv_viterbi_dec_if.slave bus
);
   localparam int STEP_W = $clog2(FRAME_LEN);
   localparam int OUT_W  = $clog2(FRAME_LEN + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACS   = 2'd1;
   localparam logic [1:0] S_TRACE = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic [PM_W-1:0]   PM_MAX    = '1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAME_LEN - 1);
   localparam logic [OUT_W-1:0]  OUT_DONE  = OUT_W'(FRAME_LEN);

   logic [1:0]           fsm;
   logic [STEP_W-1:0]    step;
   logic [1:0]           start_state;
   logic [PM_W-1:0]      pm [4];
   logic [3:0]           surv [FRAME_LEN];
   logic [FRAME_LEN-1:0] dec_bits;
   logic [1:0]           tb_state;
   logic [PM_W-1:0]      final_metric;
   logic [OUT_W-1:0]     out_idx;
   logic                 data_q;
   logic                 valid_q;
   logic [PM_W-1:0]      metric_q;

   logic                 accept;
   logic [1:0]           start_eff;
   logic [PM_W-1:0]      pm_src [4];
   logic [PM_W-1:0]      pm_new [4];
   logic [3:0]           dec_word;
   logic [1:0]           best_state;
   logic [PM_W-1:0]      best_metric;
   logic                 first_trace;
   logic [1:0]           cur_state;
   logic                 trace_dec;

   function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic d,
                                                input logic a, input logic b);
      logic v1;
      logic v2;
      v1 = d ^ s[0] ^ s[1];
      v2 = d ^ s[1];
      return {1'b0, v1 ^ a} + {1'b0, v2 ^ b};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
      logic [PM_W:0] sum;
      sum = {1'b0, a} + (PM_W + 1)'(b);
      return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
   endfunction

   assign accept    = bus.valid_in && ((fsm == S_IDLE) || (fsm == S_ACS));
   assign start_eff = ((fsm == S_IDLE) && bus.load) ? bus.seed : start_state;

   // In IDLE the ACS reads a freshly initialised metric set, so stale metrics never leak across frames.
   for (genvar g = 0; g < 4; g++) begin : g_acs
      localparam logic [1:0] NS = 2'(g);
      localparam logic [1:0] P0 = {1'b0, NS[1]};
      localparam logic [1:0] P1 = {1'b1, NS[1]};
      logic [PM_W-1:0] c0;
      logic [PM_W-1:0] c1;

      assign pm_src[g]   = (fsm == S_IDLE) ? ((start_eff == NS) ? '0 : PM_MAX) : pm[g];
      assign c0          = sat_add(pm_src[P0], branch_metric(P0, NS[0], bus.r1, bus.r2));
      assign c1          = sat_add(pm_src[P1], branch_metric(P1, NS[0], bus.r1, bus.r2));
      assign dec_word[g] = (c1 < c0);
      assign pm_new[g]   = (c1 < c0) ? c1 : c0;
   end

   always_comb begin
      best_state  = 2'd0;
      best_metric = pm[0];
`ifndef VITDEC_ZERO_TERM_EN
      for (int i = 1; i < 4; i++) begin
         if (pm[i] < best_metric) begin
            best_metric = pm[i];
            best_state  = 2'(i);
         end
      end
`endif
   end

   assign first_trace = (step == STEP_LAST);
   assign cur_state   = first_trace ? best_state : tb_state;
   assign trace_dec   = surv[step][cur_state];

   always_ff @(posedge clk) begin
      if (accept) begin
         surv[step] <= dec_word;
      end
      if (fsm == S_TRACE) begin
         dec_bits[step] <= cur_state[0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm          <= S_IDLE;
         step         <= '0;
         start_state  <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            pm[i] <= (i == 0) ? '0 : PM_MAX;
         end
         tb_state     <= 2'd0;
         final_metric <= '0;
         out_idx      <= '0;
         data_q       <= 1'b0;
         valid_q      <= 1'b0;
         metric_q     <= '0;
      end else begin
         case (fsm)
            S_IDLE: begin
               if (bus.load) begin
                  start_state <= bus.seed;
               end
               if (bus.valid_in) begin
                  pm   <= pm_new;
                  step <= STEP_W'(1);
                  fsm  <= S_ACS;
               end
            end
            S_ACS: begin
               if (bus.valid_in) begin
                  pm <= pm_new;
                  if (step == STEP_LAST) begin
                     fsm <= S_TRACE;
                  end else begin
                     step <= step + STEP_W'(1);
                  end
               end
            end
            S_TRACE: begin
               if (first_trace) begin
                  final_metric <= best_metric;
               end
               tb_state <= {trace_dec, cur_state[1]};
               if (step == '0) begin
                  fsm     <= S_OUT;
                  out_idx <= '0;
               end else begin
                  step <= step - STEP_W'(1);
               end
            end
            default: begin
               if (out_idx == OUT_DONE) begin
                  valid_q <= 1'b0;
                  data_q  <= 1'b0;
                  step    <= '0;
                  fsm     <= S_IDLE;
               end else begin
                  valid_q  <= 1'b1;
                  data_q   <= dec_bits[out_idx];
                  metric_q <= final_metric;
                  out_idx  <= out_idx + OUT_W'(1);
               end
            end
         endcase
      end
   end

   assign bus.ready      = (fsm == S_IDLE) || (fsm == S_ACS);
   assign bus.data_out   = data_q;
   assign bus.valid_out  = valid_q;
   assign bus.metric_out = metric_q;
endmodule

// File: doc/conv_viterbi_dec.md
# conv_viterbi_dec

Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code (generators 7/5 octal). It sits at the receive end of the coded link, opposite the `convenc` encoder. It takes one received (v1, v2) symbol pair per accepted cycle, decodes a fixed-length frame by add-compare-select and full-frame traceback, and then streams the decoded bits out in original order with a frame path-metric report.

## Interface
- `FRAME_LEN`, 40: information bits (symbol pairs) per frame; ≥ 4.
- `PM_W`, 8: path-metric width; adds saturate at 2^PM_W−1.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: in IDLE, captures `seed` as the frame start state.
- `seed` input 2: start state {sr1, sr0}.
- `valid_in` input 1: `r1`/`r2` valid; accepted only when `ready`=1.
- `r1` input 1: received hard bit for v1.
- `r2` input 1: received hard bit for v2.
- `ready` output 1: decoder accepts symbols (IDLE or ACS).
- `data_out` output 1: decoded bit.
- `valid_out` output 1: `data_out` valid, one bit per cycle.
- `metric_out` output PM_W: final path metric of the traced state; valid while `valid_out`=1.

## Operation
- **Code definition:**
  - Encoder shift register sr[1:0]; state S = {sr1, sr0}.
  - For input d: v1 = d^sr0^sr1, v2 = d^sr1.
  - Next state S' = {S[0], d}.
- **Branch metric:** Hamming distance (0–2) between the expected (v1, v2) and (r1, r2).
- **FSM states:**
  - IDLE: `ready`=1. `load`=1 latches `seed` into start_state. Reset value of start_state is 0. The first accepted symbol is processed as step 0, and the FSM moves to ACS.
  - ACS: `ready`=1. Each accepted pair updates all 4 metrics, writes one 4-bit decision word to survivor memory[step], and increments step. After step FRAME_LEN−1 is accepted, the FSM moves to TRACE. Cycles with `valid_in`=0 hold all state.
  - TRACE: `ready`=0. Selects the final state, then walks back one step per cycle for FRAME_LEN cycles. For state S', the decoded bit is S'[0] and the predecessor is {dec[S'], S'[1]}. Bits are written into a FRAME_LEN-bit output register at index step.
  - OUT: `ready`=0. Emits bits 0 to FRAME_LEN−1 with `valid_out`=1, one per cycle, then returns to IDLE.
- **Metric initialisation at frame start:** the start state gets 0; the other three states get 2^PM_W−1.
- **ACS rules:**
  - Predecessors of S' = {x, y} are {0, x} and {1, x}, with input y.
  - new = min of saturating (pm_pred + bm).
  - The decision bit is the chosen predecessor's S[1]. On a tie, predecessor S[1]=0 wins.
- **Final state selection:** the state with the minimum metric; ties go to the lowest index. `metric_out` is that state's metric.
- **Input gating:** `valid_in` during TRACE or OUT is ignored and not queued. `load` outside IDLE is ignored.
- **Reset mid-frame:** the frame is discarded. FSM goes to IDLE, step to 0, start_state to 0, metrics to the initial values, all outputs to 0.
- **Output reset values:** `ready`=1, `data_out`=0, `valid_out`=0, `metric_out`=0.

## Timing
- An accepted symbol's metrics are updated at the same rising edge.
- The last symbol is accepted at edge E.
  - Edge E+1: final state selected and first traceback step done.
  - Edges E+1 to E+FRAME_LEN: traceback.
  - Edges E+FRAME_LEN+1 to E+2·FRAME_LEN: `valid_out` high with bits 0 to FRAME_LEN−1.
- `ready` returns to 1 in the cycle after the last output bit. A back-to-back frame may start there.
- `data_out`, `valid_out`, and `metric_out` are registered outputs.

## Configuration
- `VITDEC_ZERO_TERM_EN`:
  - **Defined:** the frame is assumed zero-tail terminated. Traceback always starts from state 0, and `metric_out` = pm[0].
  - **Undefined:** the best-metric state is selected as described above.

## Test plan
- **Error-free all-zero frame:** FRAME_LEN pairs of (0,0) -> FRAME_LEN zeros out, `metric_out`=0, first `valid_out` at E+FRAME_LEN+1.
- **Impulse:** input bits 1,0,0,… encoded as pairs 11,10,11,00,… -> `data_out` 1 then zeros; `metric_out`=0.
- **Single error:** flip r1 of pair 5 of a 40-bit pattern 1011001110… encoded with start state 0 -> original bits recovered; `metric_out`=1.
- **Gaps and ignored inputs:**
  - Drive `valid_in` with 1-cycle gaps mid-frame -> identical output to the gapless run.
  - Drive `valid_in`=1 during TRACE/OUT -> no effect.
- **Seed and termination:**
  - `load`=1 with `seed`=2'b11, then a frame encoded from state 11 -> correct decode, `metric_out`=0.
  - Same frame with no tail under `VITDEC_ZERO_TERM_EN` defined -> nonzero metric allowed.
- **Reset mid-frame:** assert `reset`=0 at step 20 -> `ready`=1, `valid_out`=0 immediately. A fresh all-zero frame afterwards decodes to zeros with `metric_out`=0.
